fetch_buffer: RTL and testbench

- Decoupling instruction queue between the fetch stage and the decode stage in the superscalar frontend.
- Accepts up to FETCH_W instruction/PC pairs per cycle from fetch and presents up to FETCH_W oldest entries, in program order, to decode.
- Absorbs decode backpressure and drives fetch stall through in_ready.
- Discards all contents on a pipeline redirect (flush).

---
 rtl/fetch_buffer.sv | 151 +++++++++++++++
 tb/tb_fetch_buffer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//
// Instruction queue between the fetch stage and the decode stage. It accepts up
// to FETCH_W {pc, instr} pairs per cycle and presents the FETCH_W oldest
// entries, oldest first, to decode. Decode backpressure reaches fetch through
// in_ready. A flush (pipeline redirect) discards the whole contents.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : asynchronous active-low reset
//   in_valid   : per-lane valid from fetch
//   in_pc      : per-lane PC from fetch
//   in_instr   : per-lane instruction word from fetch
//   in_ready   : room for a full FETCH_W group (fetch stalls when low)
//   flush      : redirect, drops all entries and same-cycle traffic
//   out_valid  : per-lane valid to decode, lane 0 is the oldest entry
//   out_pc     : PC per output lane (zero when the lane is invalid)
//   out_instr  : instruction per output lane (zero when the lane is invalid)
//   out_ready  : decode takes every valid output lane this cycle
//   count      : current occupancy
// -----------------------------------------------------------------------------
module fetch_buffer #(
  parameter int FETCH_W = 2,
  parameter int XLEN    = 32,
  parameter int DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [FETCH_W-1:0]            in_valid,
  input  logic [FETCH_W-1:0][XLEN-1:0]  in_pc,
  input  logic [FETCH_W-1:0][XLEN-1:0]  in_instr,
  output logic                          in_ready,
  input  logic                          flush,
  output logic [FETCH_W-1:0]            out_valid,
  output logic [FETCH_W-1:0][XLEN-1:0]  out_pc,
  output logic [FETCH_W-1:0][XLEN-1:0]  out_instr,
  input  logic                          out_ready,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Highest occupancy that still leaves room for a whole FETCH_W group.
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - FETCH_W);

  // ---------------------------------------------------------------------------
  // Storage (contents are deliberately left unreset)
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] mem_pc_q    [DEPTH];
  logic [XLEN-1:0] mem_instr_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Pointers and occupancy
  // ---------------------------------------------------------------------------
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          enq_fire;
  logic          deq_fire;
  logic [CW-1:0] n_enq;
  logic [CW-1:0] n_deq;

  logic [AW-1:0] wr_addr [FETCH_W];
  logic [AW-1:0] rd_addr [FETCH_W];

  function automatic logic [CW-1:0] popcnt(input logic [FETCH_W-1:0] v);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      s = s + CW'(v[i]);
    end
    return s;
  endfunction

  // Registered count only: no credit for a same-cycle dequeue, which keeps
  // out_ready off the in_ready path.
  assign in_ready = (count_q <= READY_MAX);
  assign count    = count_q;

  assign enq_fire = in_ready && !flush;
  assign deq_fire = out_ready && !flush;
  assign n_enq    = popcnt(in_valid);
  assign n_deq    = popcnt(out_valid);

  // ---------------------------------------------------------------------------
  // Per-lane address generation and output read
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_lane
      // Valid lanes are compacted: a lane lands after every lower valid lane.
      localparam logic [FETCH_W-1:0] LOWER_MASK = FETCH_W'((1 << gi) - 1);

      assign wr_addr[gi] = tail_q + AW'(popcnt(in_valid & LOWER_MASK));
      assign rd_addr[gi] = head_q + AW'(gi);

      assign out_valid[gi] = !flush && (count_q > CW'(gi));
      assign out_pc[gi]    = out_valid[gi] ? mem_pc_q[rd_addr[gi]]    : '0;
      assign out_instr[gi] = out_valid[gi] ? mem_instr_q[rd_addr[gi]] : '0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Storage write (compacted lanes never collide on an address)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int l = 0; l < FETCH_W; l++) begin
      if (enq_fire && in_valid[l]) begin
        mem_pc_q[wr_addr[l]]    <= in_pc[l];
        mem_instr_q[wr_addr[l]] <= in_instr[l];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic; flush wins over enqueue and dequeue
  // ---------------------------------------------------------------------------
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) begin
        tail_d = tail_q + AW'(n_enq);
      end
      if (deq_fire) begin
        head_d = head_q + AW'(n_deq);
      end
      count_d = count_q + (enq_fire ? n_enq : '0) - (deq_fire ? n_deq : '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_fetch_buffer
//
// Directed scenarios followed by randomized traffic. A queue-based model of the
// buffer predicts in_ready, out_* and count every cycle; a few literal checks
// pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_fetch_buffer;

  localparam int FETCH_W = 2;
  localparam int XLEN    = 32;
  localparam int DEPTH   = 8;

  localparam logic [31:0] ADD_X1  = 32'h003100B3;  // add  x1,x2,x3
  localparam logic [31:0] ADDI_X4 = 32'h06428213;  // addi x4,x5,100

  logic                         clk;
  logic                         reset;
  logic [FETCH_W-1:0]           in_valid;
  logic [FETCH_W-1:0][XLEN-1:0] in_pc;
  logic [FETCH_W-1:0][XLEN-1:0] in_instr;
  logic                         in_ready;
  logic                         flush;
  logic [FETCH_W-1:0]           out_valid;
  logic [FETCH_W-1:0][XLEN-1:0] out_pc;
  logic [FETCH_W-1:0][XLEN-1:0] out_instr;
  logic                         out_ready;
  logic [3:0]                   count;

  fetch_buffer #(.FETCH_W(FETCH_W), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_pc    (in_pc),
    .in_instr (in_instr),
    .in_ready (in_ready),
    .flush    (flush),
    .out_valid(out_valid),
    .out_pc   (out_pc),
    .out_instr(out_instr),
    .out_ready(out_ready),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Model: a plain FIFO of entries, oldest at index 0
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t q[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          track_seq = 0;
  logic [31:0] last_pc;
  int          deq_total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %0s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return (DEPTH - q.size()) >= FETCH_W;
  endfunction

  // Compare every DUT output against the model for the inputs now applied.
  task automatic compare_now();
    logic [1:0]  ev;
    logic [31:0] epc, eins;
    ev = '0;
    chk("in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
    chk("count", {28'd0, count}, q.size());
    chk("count_bound", {31'd0, (count <= DEPTH)}, 32'd1);
    for (int i = 0; i < FETCH_W; i++) begin
      ev[i] = (q.size() > i) && !flush;
      epc   = ev[i] ? q[i].pc  : 32'd0;
      eins  = ev[i] ? q[i].ins : 32'd0;
      chk($sformatf("out_pc[%0d]", i), out_pc[i], epc);
      chk($sformatf("out_instr[%0d]", i), out_instr[i], eins);
    end
    chk("out_valid", {30'd0, out_valid}, {30'd0, ev});
  endtask

  // Apply one clock edge to the model using the inputs now applied.
  task automatic model_next();
    bit rdy;
    int n;
    ent_t e;
    rdy = model_ready();
    if (flush) begin
      q.delete();
    end else begin
      if (out_ready) begin
        n = (q.size() < FETCH_W) ? q.size() : FETCH_W;
        for (int i = 0; i < n; i++) begin
          e = q.pop_front();
          if (track_seq) begin
            chk("seq_pc", e.pc, last_pc + 32'd4);
            last_pc = e.pc;
            deq_total++;
          end
        end
      end
      if (rdy) begin
        for (int i = 0; i < FETCH_W; i++) begin
          if (in_valid[i]) q.push_back('{pc: in_pc[i], ins: in_instr[i]});
        end
      end
    end
  endtask

  // One cycle: drive, check, advance model, clock, then return inputs to idle.
  task automatic step(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                      input logic [31:0] i0, input logic [31:0] i1,
                      input logic ordy, input logic fl);
    in_valid    = v;
    in_pc[0]    = p0;
    in_pc[1]    = p1;
    in_instr[0] = i0;
    in_instr[1] = i1;
    out_ready   = ordy;
    flush       = fl;
    #1;
    compare_now();
    model_next();
    @(posedge clk);
    #2;
    in_valid  = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  logic [31:0] nxt_pc;
  logic [1:0]  rv;
  logic [31:0] rp0, rp1, ri0, ri1;
  bit          acc;

  initial begin
    reset    = 1'b0;
    in_valid = '0;
    in_pc    = '0;
    in_instr = '0;
    flush    = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {30'd0, out_valid}, 32'd0);
    chk("rst_out_pc0", out_pc[0], 32'd0);
    #1 reset = 1'b1;

    // Ordered enqueue
    step(2'b11, 32'h0, 32'h4, ADD_X1, ADDI_X4, 1'b0, 1'b0);
    chk("ord_count", {28'd0, count}, 32'd2);
    chk("ord_valid", {30'd0, out_valid}, 32'd3);
    chk("ord_pc0", out_pc[0], 32'h0);
    chk("ord_pc1", out_pc[1], 32'h4);
    chk("ord_ins0", out_instr[0], ADD_X1);

    // Fill and backpressure
    step(2'b11, 32'h8,  32'hC,  32'h8,  32'hC,  1'b0, 1'b0);
    step(2'b11, 32'h10, 32'h14, 32'h10, 32'h14, 1'b0, 1'b0);
    step(2'b11, 32'h18, 32'h1C, 32'h18, 32'h1C, 1'b0, 1'b0);
    chk("full_count", {28'd0, count}, 32'd8);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    step(2'b11, 32'h20, 32'h24, 32'h20, 32'h24, 1'b0, 1'b0);
    chk("held_count", {28'd0, count}, 32'd8);
    step(2'b11, 32'h20, 32'h24, 32'h20, 32'h24, 1'b1, 1'b0);
    chk("drain_pc0", out_pc[0], 32'h8);
    chk("drain_pc1", out_pc[1], 32'hC);
    chk("drain_count", {28'd0, count}, 32'd6);
    chk("drain_in_ready", {31'd0, in_ready}, 32'd1);

    // Partial lane into an empty buffer
    step(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(2'b10, 32'hDEAD, 32'h14, 32'hBAD, 32'h14, 1'b0, 1'b0);
    chk("part_valid", {30'd0, out_valid}, 32'd1);
    chk("part_pc0", out_pc[0], 32'h14);
    chk("part_count", {28'd0, count}, 32'd1);
    step(2'b11, 32'h18, 32'h1C, 32'h18, 32'h1C, 1'b0, 1'b0);
    chk("part2_pc0", out_pc[0], 32'h14);
    chk("part2_pc1", out_pc[1], 32'h18);
    chk("part2_count", {28'd0, count}, 32'd3);

    // Flush collision at count=5
    step(2'b11, 32'h20, 32'h24, 32'h20, 32'h24, 1'b0, 1'b0);
    chk("pre_flush_count", {28'd0, count}, 32'd5);
    step(2'b11, 32'h40, 32'h44, 32'h40, 32'h44, 1'b1, 1'b1);
    chk("flush_count", {28'd0, count}, 32'd0);
    chk("flush_valid", {30'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    step(2'b11, 32'h40, 32'h44, 32'h40, 32'h44, 1'b0, 1'b0);
    chk("post_flush_pc0", out_pc[0], 32'h40);

    // Wrap-around streaming
    step(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    track_seq = 1;
    last_pc   = 32'hFFFF_FFFC;
    deq_total = 0;
    nxt_pc    = 32'h0;
    for (int c = 0; c < 30; c++) begin
      acc = model_ready();
      step(2'b11, nxt_pc, nxt_pc + 32'd4, ~nxt_pc, ~(nxt_pc + 32'd4), (c % 3) != 2, 1'b0);
      if (acc) nxt_pc = nxt_pc + 32'd8;
    end
    track_seq = 0;
    chk("wrap_deq_enough", {31'd0, (deq_total >= 17)}, 32'd1);

    // Asynchronous reset at count=6
    step(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(2'b11, 32'h60, 32'h64, 32'h1, 32'h2, 1'b0, 1'b0);
    step(2'b11, 32'h68, 32'h6C, 32'h3, 32'h4, 1'b0, 1'b0);
    step(2'b11, 32'h70, 32'h74, 32'h5, 32'h6, 1'b0, 1'b0);
    chk("pre_rst_count", {28'd0, count}, 32'd6);
    #1 reset = 1'b0;
    #1;
    chk("arst_count", {28'd0, count}, 32'd0);
    chk("arst_valid", {30'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    q.delete();
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    step(2'b11, 32'h100, 32'h104, 32'h7, 32'h8, 1'b0, 1'b0);
    chk("post_rst_pc0", out_pc[0], 32'h100);
    chk("post_rst_pc1", out_pc[1], 32'h104);

    // Randomized traffic; fetch holds a group until it is accepted
    rv  = 2'($urandom_range(0, 3));
    rp0 = $urandom; rp1 = $urandom; ri0 = $urandom; ri1 = $urandom;
    for (int c = 0; c < 500; c++) begin
      logic ordy, fl;
      ordy = ($urandom_range(0, 99) < 55);
      fl   = ($urandom_range(0, 99) < 5);
      acc  = model_ready() || fl;
      step(rv, rp0, rp1, ri0, ri1, ordy, fl);
      if (acc) begin
        rv  = 2'($urandom_range(0, 3));
        rp0 = $urandom; rp1 = $urandom; ri0 = $urandom; ri1 = $urandom;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
